// File: rtl/dpram_arbiter.sv
// dpram_arbiter: clears an 8x16 dual-port memory after reset, then shares its
// write port between two writers and its read port between two readers using
// per-port two-way round-robin arbitration. All outputs are registered.

// Two-requester round-robin pick: the pointer client wins if it asks,
// otherwise the other client wins. Purely combinational.
module dpram_arbiter_rr2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       any_o,
    output logic       win_o,
    output logic [1:0] gnt_o
);

    // Choose the winner and build the one-hot grant.
    always_comb begin
        any_o = |req_i;
        win_o = req_i[ptr_i] ? ptr_i : ~ptr_i;
        gnt_o = 2'b00;
        if (any_o) gnt_o[win_o] = 1'b1;
    end

endmodule

module dpram_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [1:0]        wreq,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        wgnt,
    input  logic [1:0]        rreq,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [1:0]        rgnt,
    output logic [1:0]        rvld,
    output logic              init_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_rd_addr
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                wptr_q, wptr_d;
    logic                rptr_q, rptr_d;
    logic [1:0]          wgnt_q, wgnt_d;
    logic [1:0]          rgnt_q, rgnt_d;
    logic [1:0]          rvld_q, rvld_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                re_q, re_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;

    // Port 0 is the write port, port 1 the read port; each has its own pointer.
    logic [1:0][1:0] arb_req;
    logic [1:0][1:0] arb_gnt;
    logic [1:0]      arb_ptr;
    logic [1:0]      arb_any;
    logic [1:0]      arb_win;

    assign arb_req[0] = wreq;
    assign arb_req[1] = rreq;
    assign arb_ptr    = {rptr_q, wptr_q};

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_arb
            dpram_arbiter_rr2 u_rr (
                .req_i (arb_req[p]),
                .ptr_i (arb_ptr[p]),
                .any_o (arb_any[p]),
                .win_o (arb_win[p]),
                .gnt_o (arb_gnt[p])
            );
        end
    endgenerate

    // Next-state: clear sweep in INIT, then per-port arbitration in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        wgnt_d  = 2'b00;
        rgnt_d  = 2'b00;
        rvld_d  = 2'b00;
        busy_d  = busy_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        re_d    = 1'b0;
        ra_d    = ra_q;
        case (state_q)
            S_INIT: begin
                // Requests are left pending; only clear writes go out.
                we_d  = 1'b1;
                wa_d  = cnt_q;
                wd_d  = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                // The memory registers read data one cycle after mem_re,
                // so the valid strobe trails the read grant by one cycle.
                rvld_d = rgnt_q;
                if (arb_any[0]) begin
                    wgnt_d = arb_gnt[0];
                    we_d   = 1'b1;
                    wa_d   = arb_win[0] ? waddr1 : waddr0;
                    wd_d   = arb_win[0] ? wdata1 : wdata0;
                    wptr_d = ~arb_win[0];
                end
                if (arb_any[1]) begin
                    rgnt_d = arb_gnt[1];
                    re_d   = 1'b1;
                    ra_d   = arb_win[1] ? raddr1 : raddr0;
                    rptr_d = ~arb_win[1];
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // State and output registers; reset drops everything and restarts the clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            wgnt_q  <= 2'b00;
            rgnt_q  <= 2'b00;
            rvld_q  <= 2'b00;
            busy_q  <= 1'b1;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            re_q    <= 1'b0;
            ra_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            wgnt_q  <= wgnt_d;
            rgnt_q  <= rgnt_d;
            rvld_q  <= rvld_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            re_q    <= re_d;
            ra_q    <= ra_d;
        end
    end

    assign wgnt        = wgnt_q;
    assign rgnt        = rgnt_q;
    assign rvld        = rvld_q;
    assign init_busy   = busy_q;
    assign mem_we      = we_q;
    assign mem_wr_addr = wa_q;
    assign mem_data_in = wd_q;
    assign mem_re      = re_q;
    assign mem_rd_addr = ra_q;

endmodule
